serializer_multilane: RTL
=========================

Name: serializer_multilane

Overview:
Parametrised successor to the single-bit serializer in the FIR filter datapath. It accepts a LENGTH-bit parallel word through a valid/ready handshake and emits it as BEATS = LENGTH/LANES beats of LANES bits each. Bit order is selectable (LSB-first or MSB-first), and each beat carries first/last framing flags. Consecutive words stream back-to-back with no idle gap, so one instance can feed multi-lane serial links between filter stages.

Parameters:
LENGTH, 24, parallel word width in bits (>= 1)
LANES, 1, bits output per beat; must divide LENGTH evenly (elaboration-time $error otherwise)
MSB_FIRST, 0, 0 = LSB-first, 1 = MSB-first

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  clock enable; low = stall, all state held
i_din_valid  input  1  iv_din holds a word to load
o_din_ready  output  1  block can accept a word this cycle
iv_din  input  LENGTH  parallel word
ov_dout  output  LANES  current beat
o_dout_valid  output  1  ov_dout holds a valid beat
o_dout_first  output  1  current beat is beat 0 of its word
o_dout_last  output  1  current beat is beat BEATS-1 of its word
o_busy  output  1  a word is being shifted out (equals o_dout_valid)

Behaviour:
- Reset (i_rst_n = 0, asynchronous): state IDLE; shift register, beat counter, ov_dout, o_dout_valid, o_dout_first, o_dout_last and o_busy all 0. Reset mid-word aborts the word; no partial beats after release.
- Beat counter width is max(1, $clog2(BEATS)).
- States:
  - IDLE: o_din_ready = i_en.
  - SHIFT: o_din_ready = i_en & o_dout_last.
  - o_din_ready is combinational.
- Accept: a rising edge with i_din_valid & o_din_ready latches iv_din, clears the counter and enters (or stays in) SHIFT.
- Latency: beat 0 is on ov_dout with o_dout_valid = 1 and o_dout_first = 1 immediately after the accepting edge.
- Advance: in SHIFT, each edge with i_en = 1 increments the beat. After the edge that consumes beat BEATS-1:
  - if a word was accepted on that same edge, SHIFT continues with the new word's beat 0 (gapless);
  - otherwise the block returns to IDLE and ov_dout and all flags go to 0.
- Stall: with i_en = 0, no state change, outputs hold their values and o_din_ready = 0. i_din_valid is ignored.
- Beat j mapping:
  - LSB-first: ov_dout = word[j*LANES +: LANES].
  - MSB-first: ov_dout = word[LENGTH-1-j*LANES -: LANES].
  - In both modes, lane index follows bit significance (ov_dout[LANES-1] is the more significant bit).
- BEATS = 1 (LANES = LENGTH): every beat is both first and last; ready stays high while enabled, giving one word per cycle.
- When not ready, i_din_valid and iv_din are don't-care. The block does not require the upstream to hold its word.

Test Plan:
- LENGTH=24, LANES=1, LSB-first, load 0xA5C3F0 while idle -> 24 beats starting the cycle after acceptance: 0,0,0,0,1,1,1,1,...; first flag on beat 0, last flag on beat 23; returns to IDLE and valid=0 after beat 23.
- LANES=4, MSB-first, word 0x123456 -> 6 beats 0x1,0x2,0x3,0x4,0x5,0x6; o_din_ready high only during beat 5.
- Back-to-back: LANES=8, LSB-first, 0x112233 then 0xAABBCC with valid held high -> beats 0x33,0x22,0x11,0xCC,0xBB,0xAA with no gap; first flag on 0x33 and 0xCC.
- Stall: drop i_en for 3 cycles during beat 2 of 0x123456 (LANES=4) -> ov_dout stays 0x3 (MSB-first) for 4 cycles total, no beat lost or repeated, ready=0 throughout the stall.
- Reset mid-word at beat 10 of a 24-beat word -> all outputs 0 asynchronously, before the next edge; after release, ready=1 when i_en=1 and the next word starts cleanly at beat 0.
- LANES=LENGTH=24, 100 random words with valid held high -> one word per cycle, ov_dout equals iv_din delayed by one cycle, first=last=1 on every beat, 0 errors.

Source files
------------

// File: rtl/serializer_multilane_if.sv
// Handshake and beat bus between a word producer and the multi-lane serializer.
// The slave modport is the serializer's view; the master modport is the upstream/downstream view.
interface serializer_multilane_if #(
    parameter int LENGTH = 24,
    parameter int LANES  = 1
) ();
    logic              i_en;
    logic              i_din_valid;
    logic              o_din_ready;
    logic [LENGTH-1:0] iv_din;
    logic [LANES-1:0]  ov_dout;
    logic              o_dout_valid;
    logic              o_dout_first;
    logic              o_dout_last;
    logic              o_busy;

    modport slave (
        input  i_en, i_din_valid, iv_din,
        output o_din_ready, ov_dout, o_dout_valid, o_dout_first, o_dout_last, o_busy
    );

    modport master (
        output i_en, i_din_valid, iv_din,
        input  o_din_ready, ov_dout, o_dout_valid, o_dout_first, o_dout_last, o_busy
    );
endinterface

// File: rtl/serializer_multilane.sv
// Splits a LENGTH-bit word into LENGTH/LANES beats of LANES bits, LSB- or MSB-first,
// with first/last framing and gapless back-to-back word streaming.
module serializer_multilane #(
    parameter int LENGTH    = 24,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    serializer_multilane_if.slave bus
);
    localparam int BEATS = LENGTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    generate
        if (LENGTH % LANES != 0) begin : g_bad_lanes
            $error("serializer_multilane: LANES (%0d) must divide LENGTH (%0d)", LANES, LENGTH);
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [LENGTH-1:0] sreg;
    logic [CW-1:0]     beat;
    logic [LANES-1:0]  dout;
    logic              valid;
    logic              first;
    logic              last;
    logic              ready;
    logic              accept;

    // The beat leaving next always sits at the outgoing end of the shift register.
    function automatic logic [LANES-1:0] head(input logic [LENGTH-1:0] w);
        if (MSB_FIRST) return w[LENGTH-1 -: LANES];
        else           return w[LANES-1:0];
    endfunction

    function automatic logic [LENGTH-1:0] advance(input logic [LENGTH-1:0] w);
        if (MSB_FIRST) return w << LANES;
        else           return w >> LANES;
    endfunction

    // A new word can be taken while idle or while its predecessor's final beat is showing.
    assign ready  = bus.i_en & ((state == IDLE) | last);
    assign accept = ready & bus.i_din_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            beat  <= '0;
            dout  <= '0;
            valid <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= advance(bus.iv_din);
            beat  <= '0;
            dout  <= head(bus.iv_din);
            valid <= 1'b1;
            first <= 1'b1;
            last  <= (BEATS == 1);
        end else if (bus.i_en && state == SHIFT) begin
            if (last) begin
                state <= IDLE;
                sreg  <= '0;
                beat  <= '0;
                dout  <= '0;
                valid <= 1'b0;
                first <= 1'b0;
                last  <= 1'b0;
            end else begin
                beat  <= beat + CW'(1);
                dout  <= head(sreg);
                sreg  <= advance(sreg);
                first <= 1'b0;
                last  <= ((beat + CW'(1)) == LAST_BEAT);
            end
        end
    end

    assign bus.o_din_ready  = ready;
    assign bus.ov_dout      = dout;
    assign bus.o_dout_valid = valid;
    assign bus.o_dout_first = first;
    assign bus.o_dout_last  = last;
    assign bus.o_busy       = valid;
endmodule
